// File: rtl/npc_fetch_ctrl.sv
// Next-PC and instruction-fetch controller: drives the PC register input, fetches
// from instruction memory, and hands instructions to decode over valid/ready.
module npc_fetch_ctrl #(
  parameter logic [29:0] RESET_PC = 30'h0000_0c00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] pc,
  output logic [31:2] npc,
  output logic        imem_req,
  output logic [31:2] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:2] instr_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:2] redirect_target,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_pending;
  logic [31:2] r_pend_tgt;
  logic [31:0] r_instr;
  logic [31:2] r_instr_pc;
  logic [31:0] r_fetch_cnt;

  logic        w_load_instr;
  logic        w_set_pend;
  logic        w_clr_pend;
  logic        w_cnt_inc;
  logic [31:2] w_npc;

  // Next-state, next-PC and register update strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_npc        = pc;
    w_load_instr = 1'b0;
    w_set_pend   = 1'b0;
    w_clr_pend   = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      BOOT: begin
        w_npc       = RESET_PC;
        w_state_nxt = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          if (r_pending || redirect_valid) begin
            // Stale response: the fetched word belongs to a redirected-away path
            w_npc       = redirect_valid ? redirect_target : r_pend_tgt;
            w_clr_pend  = 1'b1;
            w_state_nxt = FETCH;
          end else begin
            w_npc        = pc + 30'd1;
            w_load_instr = 1'b1;
            w_state_nxt  = VALID;
          end
        end else if (redirect_valid) begin
          w_set_pend = 1'b1;
        end
      end
      VALID: begin
        if (redirect_valid) begin
          w_npc       = redirect_target;
          w_cnt_inc   = id_ready;
          w_state_nxt = FETCH;
        end else if (id_ready) begin
          w_cnt_inc   = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= BOOT;
      r_pending   <= 1'b0;
      r_pend_tgt  <= 30'd0;
      r_instr     <= 32'd0;
      r_instr_pc  <= 30'd0;
      r_fetch_cnt <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_set_pend) begin
        r_pending  <= 1'b1;
        r_pend_tgt <= redirect_target;
      end else if (w_clr_pend) begin
        r_pending <= 1'b0;
      end
      if (w_load_instr) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= pc;
      end
      if (w_cnt_inc && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
    end
  end

  assign npc         = w_npc;
  assign imem_req    = (r_state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (r_state == VALID);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign fetch_cnt   = r_fetch_cnt;

endmodule

// File: tb/tb_npc_fetch_ctrl.sv
// Directed bench for npc_fetch_ctrl with a behavioural PC register closing the npc loop.
module tb_npc_fetch_ctrl;

  localparam logic [29:0] RST_PC = 30'h0000_0c00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:2] pc;
  logic [31:2] npc;
  logic        imem_req;
  logic [31:2] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:2] instr_pc;
  logic        id_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:2] redirect_target = 30'd0;
  logic [31:0] fetch_cnt;

  int total = 0;
  int bad   = 0;

  npc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .npc            (npc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  // PC register: loads npc every edge, no enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RST_PC;
    else     pc <= npc;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ipc", 32'(instr_pc), 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("boot_npc", 32'(npc), 32'h0c00);
    chk("boot_req", 32'(imem_req), 32'd0);

    // Zero-wait memory, decode always ready
    tick();
    imem_ack = 1'b1;
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_rdata = 32'hA000_0000 + 32'(i);
      #1;
      chk("zw_req", 32'(imem_req), 32'd1);
      chk("zw_addr", 32'(imem_addr), 32'h0c00 + 32'(i));
      chk("zw_vlo", 32'(instr_valid), 32'd0);
      chk("zw_npc", 32'(npc), 32'h0c01 + 32'(i));
      tick();
      chk("zw_vhi", 32'(instr_valid), 32'd1);
      chk("zw_instr", instr, 32'hA000_0000 + 32'(i));
      chk("zw_ipc", 32'(instr_pc), 32'h0c00 + 32'(i));
      chk("zw_vreq", 32'(imem_req), 32'd0);
      tick();
    end
    chk("zw_cnt", fetch_cnt, 32'd3);

    // Delayed ack
    imem_ack = 1'b0;
    id_ready = 1'b0;
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("dl_addr", 32'(imem_addr), 32'h0c00);
      chk("dl_npc", 32'(npc), 32'h0c00);
      tick();
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'hB0B0_0001;
    tick();
    imem_ack = 1'b0;
    chk("dl_instr", instr, 32'hB0B0_0001);
    chk("dl_ipc", 32'(instr_pc), 32'h0c00);

    // Decode stall
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("st_valid", 32'(instr_valid), 32'd1);
      chk("st_instr", instr, 32'hB0B0_0001);
      chk("st_npc", 32'(npc), 32'h0c01);
      chk("st_req", 32'(imem_req), 32'd0);
      chk("st_cnt", fetch_cnt, 32'd0);
      tick();
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    chk("st_cnt1", fetch_cnt, 32'd1);

    // Redirect during outstanding request (FETCH at 0x0c01)
    redirect_valid  = 1'b1;
    redirect_target = 30'h2000;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("rd_addr_hold", 32'(imem_addr), 32'h0c01);
    chk("rd_req_hold", 32'(imem_req), 32'd1);
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_npc_pend", 32'(npc), 32'h2000);
    tick();
    imem_ack = 1'b0;
    chk("rd_vlo", 32'(instr_valid), 32'd0);
    chk("rd_addr_tgt", 32'(imem_addr), 32'h2000);
    chk("rd_instr_keep", instr, 32'hB0B0_0001);
    tick();
    imem_ack        = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 30'h3000;
    #1;
    chk("rd2_npc", 32'(npc), 32'h3000);
    tick();
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    chk("rd2_addr", 32'(imem_addr), 32'h3000);
    chk("rd2_vlo", 32'(instr_valid), 32'd0);

    // Redirect in VALID, decode not ready: drop
    imem_ack   = 1'b1;
    imem_rdata = 32'hC000_0001;
    tick();
    imem_ack        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 30'h0100;
    #1;
    chk("rv0_npc", 32'(npc), 32'h0100);
    tick();
    redirect_valid = 1'b0;
    chk("rv0_vlo", 32'(instr_valid), 32'd0);
    chk("rv0_cnt", fetch_cnt, 32'd1);
    chk("rv0_addr", 32'(imem_addr), 32'h0100);

    // Redirect in VALID, decode ready: consumed
    imem_ack = 1'b1;
    tick();
    imem_ack        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 30'h0200;
    id_ready        = 1'b1;
    tick();
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    chk("rv1_cnt", fetch_cnt, 32'd2);
    chk("rv1_addr", 32'(imem_addr), 32'h0200);

    // Wrap of pc+1 at the top of the address space
    imem_ack = 1'b1;
    tick();
    imem_ack        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 30'h3FFF_FFFF;
    id_ready        = 1'b1;
    tick();
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    chk("wr_addr", 32'(imem_addr), 32'h3FFF_FFFF);
    imem_ack   = 1'b1;
    imem_rdata = 32'hE000_0001;
    #1;
    chk("wr_npc", 32'(npc), 32'd0);
    tick();
    imem_ack = 1'b0;
    chk("wr_ipc", 32'(instr_pc), 32'h3FFF_FFFF);
    chk("wr_pc", 32'(pc), 32'd0);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;

    // Reset during an outstanding fetch; late ack must be ignored
    chk("rr_req_pre", 32'(imem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rr_req_async", 32'(imem_req), 32'd0);
    chk("rr_instr_async", instr, 32'd0);
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0BAD;
    rst        = 1'b0;
    #1;
    chk("rr_boot_req", 32'(imem_req), 32'd0);
    chk("rr_boot_npc", 32'(npc), 32'h0c00);
    tick();
    imem_ack = 1'b0;
    chk("rr_valid", 32'(instr_valid), 32'd0);
    chk("rr_instr", instr, 32'd0);
    chk("rr_addr", 32'(imem_addr), 32'h0c00);
    chk("rr_req", 32'(imem_req), 32'd1);
    chk("rr_cnt", fetch_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
